// File: rtl/subword_mem_unit.sv
// subword_mem_unit: load/store engine that runs word, byte and halfword
// accesses against a word-wide, word-addressed synchronous RAM without byte
// strobes. Sub-word stores are read-modify-write; loads are zero- or
// sign-extended.
// Optional feature: define SUBWORD_ALIGN_CHECK_EN to reject misaligned word
// and halfword accesses with err.
module subword_mem_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_en,
  output logic        mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_t;

  state_t      state_q, state_d;
  logic        accept;
  logic        req_reject;

  // Captured request; only bits [15:0] of the store data matter after accept.
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;

  logic [31:0] rdata_q, rdata_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [29:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;

  logic [31:0] merged_word;
  logic [31:0] load_word;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  // Classify the incoming request: illegal {we,be} codes, plus misalignment
  // when the alignment check is built in.
  always_comb begin
    if (we) req_reject = !(be == 4'b0000 || be == 4'b0001 || be == 4'b0011);
    else    req_reject = !(be == 4'b0000 || be == 4'b0001 || be == 4'b0010 ||
                           be == 4'b0100 || be == 4'b1000);
`ifdef SUBWORD_ALIGN_CHECK_EN
    if (be == 4'b0000 && addr[1:0] != 2'b00) req_reject = 1'b1;
    if (((we && be == 4'b0011) || (!we && (be == 4'b0010 || be == 4'b1000)))
        && addr[0]) req_reject = 1'b1;
`endif
  end

  // Next-state and status decode of the access FSM.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    accept  = 1'b0;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (req) begin
          accept = 1'b1;
          if (req_reject)         state_d = S_RESP;
          else if (!we)           state_d = S_READ;
          else if (be == 4'b0000) state_d = S_WRITE;
          else                    state_d = S_READ;
        end
      end
      S_READ:  state_d = we_q ? S_MERGE : S_RESP;
      S_MERGE: state_d = S_WRITE;
      S_WRITE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_RESP: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Overlay the store lane onto the word read back during MERGE.
  always_comb begin
    merged_word = mem_rdata;
    if (be_q == 4'b0001) merged_word[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
    else                 merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
  end

  // Pick the load lane (little-endian) and extend it to 32 bits.
  always_comb begin
    lane_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    lane_half = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (be_q)
      4'b0001: load_word = {24'h000000, lane_byte};
      4'b0100: load_word = {{24{lane_byte[7]}}, lane_byte};
      4'b0010: load_word = {16'h0000, lane_half};
      4'b1000: load_word = {{16{lane_half[15]}}, lane_half};
      default: load_word = mem_rdata;
    endcase
  end

  // Memory port values for the next state; registered so the RAM sees clean,
  // full-cycle levels that are zero whenever the RAM is not enabled.
  always_comb begin
    mem_en_d    = (state_d == S_READ) || (state_d == S_WRITE);
    mem_we_d    = (state_d == S_WRITE);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (mem_en_d) mem_addr_d  = accept ? addr[31:2] : addr_q[31:2];
    if (mem_we_d) mem_wdata_d = accept ? wdata : merged_word;
    rdata_d = rdata_q;
    if (state_q == S_RESP && !err_q) rdata_d = load_word;
  end

  // The load result is visible with done and held afterwards.
  assign rdata     = rdata_d;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Request capture, load result and registered memory port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      we_q        <= 1'b0;
      be_q        <= 4'b0000;
      addr_q      <= '0;
      wdata_q     <= '0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= we;
        be_q    <= be;
        addr_q  <= addr;
        wdata_q <= wdata[15:0];
        err_q   <= req_reject;
      end
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

endmodule
